// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - round-robin display-source arbiter with hold timer; manual override under DISPLAY_ARBITER_MANUAL_EN
// A granted source keeps the display until its hold timer expires; other sources wait in pending bits.
module display_arbiter #(
   parameter int HOLD_CYCLES = 50000000
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [2:0] i_req,
   input  logic       i_manual_en,
   input  logic [1:0] i_manual_sel,
   output logic [1:0] o_sel,
   output logic [2:0] o_grant,
   output logic       o_switch
);

   localparam int CW = $clog2(HOLD_CYCLES);
   localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

`ifdef DISPLAY_ARBITER_MANUAL_EN
   typedef enum logic [1:0] {IDLE, HOLD, MANUAL} state_t;
`else
   typedef enum logic [1:0] {IDLE, HOLD} state_t;
`endif

   state_t        state, state_d;
   logic [CW-1:0] cnt, cnt_d;
   logic [2:0]    pending, pending_d;
   logic [1:0]    rr_ptr, rr_ptr_d;   // index of last granted source: 0 NES, 1 PS2, 2 VCR
   logic [1:0]    sel_d;
   logic [2:0]    cand, others, win;
   logic          unused_manual;

   assign unused_manual = ^{i_manual_en, i_manual_sel};

   // First candidate after the last granted source in NES->PS2->VCR order, one-hot.
   function automatic logic [2:0] rr_pick(input logic [1:0] last, input logic [2:0] c);
      logic [2:0] w;
      case (last)
         2'd0:    w = c[1] ? 3'b010 : c[2] ? 3'b100 : c[0] ? 3'b001 : 3'b000;
         2'd1:    w = c[2] ? 3'b100 : c[0] ? 3'b001 : c[1] ? 3'b010 : 3'b000;
         default: w = c[0] ? 3'b001 : c[1] ? 3'b010 : c[2] ? 3'b100 : 3'b000;
      endcase
      return w;
   endfunction

   function automatic logic [1:0] oh2sel(input logic [2:0] oh);
      logic [1:0] s;
      case (oh)
         3'b001:  s = 2'b01;
         3'b010:  s = 2'b10;
         3'b100:  s = 2'b11;
         default: s = 2'b00;
      endcase
      return s;
   endfunction

   function automatic logic [2:0] sel2oh(input logic [1:0] s);
      logic [2:0] oh;
      case (s)
         2'b01:   oh = 3'b001;
         2'b10:   oh = 3'b010;
         2'b11:   oh = 3'b100;
         default: oh = 3'b000;
      endcase
      return oh;
   endfunction

   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      pending_d = pending;
      rr_ptr_d  = rr_ptr;
      sel_d     = o_sel;
      cand      = pending | i_req;
      others    = cand & ~o_grant;
      win       = 3'b000;

      case (state)
         IDLE: begin
            sel_d = 2'b00;
            win   = rr_pick(rr_ptr, cand);
            if (win != 3'b000) begin
               state_d   = HOLD;
               sel_d     = oh2sel(win);
               rr_ptr_d  = oh2sel(win) - 2'd1;
               cnt_d     = RELOAD;
               pending_d = cand & ~win;
            end
         end
         HOLD: begin
            if (cnt != '0) begin
               pending_d = others;
               // A waiting source blocks retrigger reloads so it cannot be starved.
               if (((i_req & o_grant) != 3'b000) && (others == 3'b000))
                  cnt_d = RELOAD;
               else
                  cnt_d = cnt - CW'(1);
            end else if (others != 3'b000) begin
               win       = rr_pick(rr_ptr, others);
               sel_d     = oh2sel(win);
               rr_ptr_d  = oh2sel(win) - 2'd1;
               cnt_d     = RELOAD;
               pending_d = others & ~win;
            end else if ((i_req & o_grant) != 3'b000) begin
               cnt_d = RELOAD;
            end else begin
               state_d = IDLE;
               sel_d   = 2'b00;
            end
         end
`ifdef DISPLAY_ARBITER_MANUAL_EN
         MANUAL: begin
            state_d   = IDLE;
            sel_d     = 2'b00;
            pending_d = 3'b000;
         end
`endif
         default: begin
            state_d = IDLE;
            sel_d   = 2'b00;
         end
      endcase

`ifdef DISPLAY_ARBITER_MANUAL_EN
      if (i_manual_en) begin
         state_d   = MANUAL;
         sel_d     = i_manual_sel;
         pending_d = 3'b000;
         cnt_d     = cnt;
         rr_ptr_d  = rr_ptr;
      end
`endif
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state    <= IDLE;
         cnt      <= '0;
         pending  <= 3'b000;
         rr_ptr   <= 2'd2;
         o_sel    <= 2'b00;
         o_grant  <= 3'b000;
         o_switch <= 1'b0;
      end else begin
         state    <= state_d;
         cnt      <= cnt_d;
         pending  <= pending_d;
         rr_ptr   <= rr_ptr_d;
         o_sel    <= sel_d;
         o_grant  <= sel2oh(sel_d);
         o_switch <= (sel_d != o_sel);
      end
   end

endmodule

// File: tb/tb_display_arbiter.sv
// tb/tb_display_arbiter.sv - directed self-checking bench for display_arbiter with HOLD_CYCLES=8
module tb_display_arbiter;

   localparam int HC = 8;
`ifdef DISPLAY_ARBITER_MANUAL_EN
   localparam bit MAN = 1'b1;
`else
   localparam bit MAN = 1'b0;
`endif

   // {o_sel, o_grant} per source
   localparam logic [4:0] S_IDLE = 5'b00_000;
   localparam logic [4:0] S_NES  = 5'b01_001;
   localparam logic [4:0] S_PS2  = 5'b10_010;
   localparam logic [4:0] S_VCR  = 5'b11_100;

   logic       i_clk = 1'b0;
   logic       i_reset = 1'b1;
   logic [2:0] i_req = 3'b000;
   logic       i_manual_en = 1'b0;
   logic [1:0] i_manual_sel = 2'b00;
   logic [1:0] o_sel;
   logic [2:0] o_grant;
   logic       o_switch;
   logic [5:0] obs;
   logic [5:0] exp_v;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   display_arbiter #(.HOLD_CYCLES(HC)) dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_req        (i_req),
      .i_manual_en  (i_manual_en),
      .i_manual_sel (i_manual_sel),
      .o_sel        (o_sel),
      .o_grant      (o_grant),
      .o_switch     (o_switch)
   );

   always #5 i_clk = ~i_clk;
   assign obs = {o_sel, o_grant, o_switch};

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

   task automatic tick();
      @(negedge i_clk);
      cyc++;
   endtask

   task automatic do_reset();
      i_req = 3'b000;
      i_manual_en = 1'b0;
      i_manual_sel = 2'b00;
      i_reset = 1'b1;
      @(negedge i_clk);
      @(negedge i_clk);
      i_reset = 1'b0;
      cyc = 0;
   endtask

   task automatic test_reset();
      @(negedge i_clk);
      checks++;
      if (obs !== 6'b0) begin
         errors++;
         $display("FAIL reset_hold: got %b expected %b", obs, 6'b0);
      end
      i_reset = 1'b0;
      repeat (3) begin
         @(negedge i_clk);
         checks++;
         if (obs !== 6'b0) begin
            errors++;
            $display("FAIL reset_idle: got %b expected %b", obs, 6'b0);
         end
      end
   endtask

   task automatic test_single_grant();
      do_reset();
      i_req = 3'b001;
      tick();
      i_req = 3'b000;
      for (int c = 1; c <= 10; c++) begin
         if (c <= 8) exp_v = {S_NES, (c == 1)};
         else        exp_v = {S_IDLE, (c == 9)};
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL single_grant c%0d: got %b expected %b", c, obs, exp_v);
         end
         tick();
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      i_req = 3'b111;
      tick();
      i_req = 3'b000;
      for (int c = 1; c <= 26; c++) begin
         if (c <= 8)       exp_v = {S_NES, (c == 1)};
         else if (c <= 16) exp_v = {S_PS2, (c == 9)};
         else if (c <= 24) exp_v = {S_VCR, (c == 17)};
         else              exp_v = {S_IDLE, (c == 25)};
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL round_robin c%0d: got %b expected %b", c, obs, exp_v);
         end
         tick();
      end
   endtask

   // NES retriggers every cycle; PS2 waits one hold window then takes over, then NES returns.
   task automatic test_anti_starvation();
      do_reset();
      i_req = 3'b001;
      tick();
      for (int c = 1; c <= 17; c++) begin
         i_req = (c == 2) ? 3'b011 : 3'b001;
         tick();
         if (c + 1 <= 9)       exp_v = {S_NES, 1'b0};
         else if (c + 1 <= 17) exp_v = {S_PS2, (c + 1 == 10)};
         else                  exp_v = {S_NES, 1'b1};
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL anti_starvation c%0d: got %b expected %b", c + 1, obs, exp_v);
         end
      end
      i_req = 3'b000;
   endtask

   task automatic test_hold_retrigger();
      do_reset();
      i_req = 3'b001;
      tick();
      for (int c = 1; c <= 32; c++) begin
         i_req = (c == 8 || c == 16 || c == 24) ? 3'b001 : 3'b000;
         tick();
         if (c + 1 <= 32) exp_v = {S_NES, 1'b0};
         else             exp_v = {S_IDLE, 1'b1};
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL hold_retrigger c%0d: got %b expected %b", c + 1, obs, exp_v);
         end
      end
      i_req = 3'b000;
   endtask

   task automatic test_manual();
      do_reset();
      i_req = 3'b001;
      tick();
      i_req = 3'b010;
      tick();
      i_req = 3'b000;
      i_manual_en = 1'b1;
      i_manual_sel = 2'b11;
      tick();
      exp_v = MAN ? {S_VCR, 1'b1} : {S_NES, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL manual_enter: got %b expected %b", obs, exp_v);
      end
      i_manual_en = 1'b0;
      tick();
      exp_v = MAN ? {S_IDLE, 1'b1} : {S_NES, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL manual_exit: got %b expected %b", obs, exp_v);
      end
      repeat (5) tick();
      exp_v = MAN ? {S_IDLE, 1'b0} : {S_PS2, 1'b1};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL manual_pending: got %b expected %b", obs, exp_v);
      end
      i_manual_sel = 2'b00;
   endtask

   task automatic test_async_reset();
      do_reset();
      i_req = 3'b111;
      tick();
      i_req = 3'b000;
      tick();
      checks++;
      if (obs !== {S_NES, 1'b0}) begin
         errors++;
         $display("FAIL async_pre: got %b expected %b", obs, {S_NES, 1'b0});
      end
      #1 i_reset = 1'b1;
      #1;
      checks++;
      if (obs !== 6'b0) begin
         errors++;
         $display("FAIL async_immediate: got %b expected %b", obs, 6'b0);
      end
      @(negedge i_clk);
      i_reset = 1'b0;
      for (int c = 0; c < 12; c++) begin
         tick();
         checks++;
         if (obs !== 6'b0) begin
            errors++;
            $display("FAIL async_no_grant c%0d: got %b expected %b", c, obs, 6'b0);
         end
      end
      i_req = 3'b011;
      tick();
      i_req = 3'b000;
      checks++;
      if (obs !== {S_NES, 1'b1}) begin
         errors++;
         $display("FAIL async_first_grant: got %b expected %b", obs, {S_NES, 1'b1});
      end
   endtask

   initial begin
      test_reset();
      test_single_grant();
      test_round_robin();
      test_anti_starvation();
      test_hold_retrigger();
      test_manual();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
